// File: rtl/sync_counter_n_pkg.sv
// Shared helpers for the parametrised synchronous counter family.
// Holds the elaboration-time legality test for the terminal modulus.
package sync_counter_n_pkg;

    // A modulus is legal when it spans at least two states and fits in WIDTH bits.
    function automatic bit modulus_ok(input int unsigned width,
                                      input longint unsigned modulus);
        return (modulus >= 64'd2) && (modulus <= (64'd1 << width));
    endfunction

endpackage

// File: rtl/sync_counter_n_tc.sv
// Terminal-count comparator.
// Drives tc_o high at the last state of the count direction:
// MODULUS-1 when counting up, 0 when counting down.
// Ports:
//   q_i   current count
//   up_i  direction (1 = up)
//   tc_o  terminal condition (combinational)
module tc_detect #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             up_i,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    assign tc_o = up_i ? (q_i == MAX_Q) : (q_i == '0);

endmodule

// File: rtl/sync_counter_n.sv
// Cascadable modulo-MODULUS up/down counter with synchronous clear and load.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low clear (wins over load)
//   load_n  synchronous active-low parallel load of d
//   enp     local count enable (does not gate rco)
//   ent     cascade count enable (gates rco)
//   up      direction, 1 = up, 0 = down
//   d       parallel load data
//   q       registered count
//   rco     ripple carry/borrow, combinational: ent & terminal count
module sync_counter_n
    import sync_counter_n_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_n,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    // Reject an illegal modulus at elaboration.
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("sync_counter_n: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             tc;

    // Next count: load, then enabled up/down step, otherwise hold.
    // Up-count uses >= so an out-of-range loaded value wraps to 0;
    // down-count of an out-of-range value simply decrements toward range.
    always_comb begin
        cnt_d = cnt_q;
        if (!load_n) begin
            cnt_d = d;
        end else if (enp && ent) begin
            if (up) begin
                cnt_d = (cnt_q >= MAX_Q) ? '0 : cnt_q + WIDTH'(1);
            end else begin
                cnt_d = (cnt_q == '0) ? MAX_Q : cnt_q - WIDTH'(1);
            end
        end
    end

    // Count register with 74163-style synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    tc_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc_detect (
        .q_i  (cnt_q),
        .up_i (up),
        .tc_o (tc)
    );

    assign q   = cnt_q;
    assign rco = ent & tc;

endmodule

// File: tb/tb_sync_counter_n.sv
// Directed self-checking bench for sync_counter_n: decade single stage,
// two-stage decade cascade, and an 8-bit binary stage.
module tb_sync_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Decade stage (WIDTH=4, MODULUS=10)
    logic       a_rst_n, a_load_n, a_enp, a_ent, a_up;
    logic [3:0] a_d, a_q;
    logic       a_rco;

    // Two-stage decade cascade
    logic       c_rst_n, c_enp;
    logic [3:0] lo_q, hi_q;
    logic       lo_rco, hi_rco;

    // Binary stage (WIDTH=8, default MODULUS)
    logic       b_rst_n, b_load_n, b_enp, b_ent, b_up;
    logic [7:0] b_d, b_q;
    logic       b_rco;

    sync_counter_n #(.WIDTH(4), .MODULUS(10)) u_dec (
        .clk(clk), .rst_n(a_rst_n), .load_n(a_load_n), .enp(a_enp), .ent(a_ent),
        .up(a_up), .d(a_d), .q(a_q), .rco(a_rco)
    );

    sync_counter_n #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .rst_n(c_rst_n), .load_n(1'b1), .enp(c_enp), .ent(1'b1),
        .up(1'b1), .d(4'd0), .q(lo_q), .rco(lo_rco)
    );

    sync_counter_n #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .rst_n(c_rst_n), .load_n(1'b1), .enp(c_enp), .ent(lo_rco),
        .up(1'b1), .d(4'd0), .q(hi_q), .rco(hi_rco)
    );

    sync_counter_n #(.WIDTH(8)) u_bin (
        .clk(clk), .rst_n(b_rst_n), .load_n(b_load_n), .enp(b_enp), .ent(b_ent),
        .up(b_up), .d(b_d), .q(b_q), .rco(b_rco)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n = 1'b1; a_load_n = 1'b1; a_enp = 1'b0; a_ent = 1'b0; a_up = 1'b1; a_d = 4'd0;
        c_rst_n = 1'b0; c_enp = 1'b0;
        b_rst_n = 1'b0; b_load_n = 1'b1; b_enp = 1'b0; b_ent = 1'b1; b_up = 1'b1; b_d = 8'd0;

        // Reset beats a simultaneous load; rco reflects q=0 and direction.
        a_rst_n = 1'b0; a_load_n = 1'b0; a_d = 4'd7; a_ent = 1'b1; a_enp = 1'b1; a_up = 1'b0;
        tick();
        check("rst_q", 32'(a_q), 32'd0);
        check("rst_rco_down", 32'(a_rco), 32'd1);
        a_up = 1'b1; #1;
        check("rst_rco_up", 32'(a_rco), 32'd0);
        tick();
        check("rst_q2", 32'(a_q), 32'd0);

        // Decade up-wrap from 8.
        a_rst_n = 1'b1; a_load_n = 1'b0; a_d = 4'd8;
        tick();
        check("up_q8", 32'(a_q), 32'd8);
        check("up_rco8", 32'(a_rco), 32'd0);
        a_load_n = 1'b1;
        tick();
        check("up_q9", 32'(a_q), 32'd9);
        check("up_rco9", 32'(a_rco), 32'd1);
        tick();
        check("up_q0", 32'(a_q), 32'd0);
        check("up_rco0", 32'(a_rco), 32'd0);
        tick();
        check("up_q1", 32'(a_q), 32'd1);
        check("up_rco1", 32'(a_rco), 32'd0);

        // Down-wrap from 1.
        a_up = 1'b0; a_load_n = 1'b0; a_d = 4'd1;
        tick();
        check("dn_q1", 32'(a_q), 32'd1);
        check("dn_rco1", 32'(a_rco), 32'd0);
        a_load_n = 1'b1;
        tick();
        check("dn_q0", 32'(a_q), 32'd0);
        check("dn_rco0", 32'(a_rco), 32'd1);
        tick();
        check("dn_q9", 32'(a_q), 32'd9);
        check("dn_rco9", 32'(a_rco), 32'd0);
        tick();
        check("dn_q8", 32'(a_q), 32'd8);

        // Out-of-range load wraps to 0 on the next up step.
        a_up = 1'b1; a_load_n = 1'b0; a_d = 4'd13;
        tick();
        check("oor_q13", 32'(a_q), 32'd13);
        check("oor_rco13", 32'(a_rco), 32'd0);
        a_load_n = 1'b1;
        tick();
        check("oor_q0", 32'(a_q), 32'd0);

        // enp alone freezes the stage while rco stays live.
        a_load_n = 1'b0; a_d = 4'd9;
        tick();
        a_load_n = 1'b1; a_enp = 1'b0; a_ent = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_q", 32'(a_q), 32'd9);
            check("hold_rco", 32'(a_rco), 32'd1);
        end
        a_ent = 1'b0; #1;
        check("hold_rco_ent0", 32'(a_rco), 32'd0);
        tick();
        check("hold_q_ent0", 32'(a_q), 32'd9);

        // Cascade: {hi,lo} runs 00..99 then wraps.
        tick();
        c_rst_n = 1'b1; c_enp = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check("cas_lo", 32'(lo_q), 32'(i % 10));
            check("cas_hi", 32'(hi_q), 32'(i / 10));
            check("cas_rco", 32'(hi_rco), (i == 99) ? 32'd1 : 32'd0);
            tick();
        end
        check("cas_wrap_lo", 32'(lo_q), 32'd0);
        check("cas_wrap_hi", 32'(hi_q), 32'd0);
        c_enp = 1'b0;

        // Binary 8-bit wrap FE, FF, 00.
        b_rst_n = 1'b1; b_load_n = 1'b0; b_d = 8'hFE;
        tick();
        check("bin_qfe", 32'(b_q), 32'hFE);
        check("bin_rcofe", 32'(b_rco), 32'd0);
        b_load_n = 1'b1; b_enp = 1'b1;
        tick();
        check("bin_qff", 32'(b_q), 32'hFF);
        check("bin_rcoff", 32'(b_rco), 32'd1);
        tick();
        check("bin_q00", 32'(b_q), 32'h00);
        check("bin_rco00", 32'(b_rco), 32'd0);
        tick();
        check("bin_q01", 32'(b_q), 32'h01);

        // Clear and load on the same edge: clear wins.
        b_rst_n = 1'b0; b_load_n = 1'b0; b_d = 8'h55;
        tick();
        check("bin_clr_wins", 32'(b_q), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
